// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and word geometry for the program loader
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    DONE,
    ERR
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_IDX_W     = 2;
  localparam int WORD_BITS      = 8 * BYTES_PER_WORD;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// rtl/imem_loader_byte_packer.sv - little-endian 4-byte insert register with byte index and full flag
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_clear,
  input  logic                  i_load,
  input  logic [7:0]            i_byte,
  output logic [WORD_BITS-1:0]  o_word,
  output logic [BYTE_IDX_W-1:0] o_idx,
  output logic                  o_full
);

  logic [WORD_BITS-1:0]  r_word;
  logic [BYTE_IDX_W-1:0] r_idx;
  logic                  r_full;

  // Clear wins over load so a word never carries bytes across the write bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_word <= '0;
      r_idx  <= '0;
      r_full <= 1'b0;
    end else if (i_clear) begin
      r_word <= '0;
      r_idx  <= '0;
      r_full <= 1'b0;
    end else if (i_load) begin
      r_word[8*r_idx +: 8] <= i_byte;
      r_idx                <= r_idx + 1'b1;
      r_full               <= (r_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
    end
  end

  assign o_word = r_word;
  assign o_idx  = r_idx;
  assign o_full = r_full;

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader writing packed words into instruction memory
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int                AWIDTH    = 32,
  parameter int                DWIDTH    = 32,
  parameter logic [AWIDTH-1:0] BASEADDR  = AWIDTH'(32'h0100_0000),
  parameter int                MAX_WORDS = 1024,
  parameter int                LEN_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  input  logic                 byte_valid_i,
  input  logic [7:0]           byte_i,
  output logic                 byte_ready_o,
  output logic [AWIDTH-1:0]    mem_addr_o,
  output logic [DWIDTH-1:0]    mem_data_o,
  output logic                 mem_write_en_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 core_hold_o
);

  state_t                r_state;
  state_t                w_next;
  logic [LEN_WIDTH-1:0]  r_len;
  logic [LEN_WIDTH-1:0]  r_word_cnt;
  logic [AWIDTH-1:0]     r_addr;
  logic                  r_core_hold;
  logic                  w_start;
  logic                  w_fire;
  logic                  w_last_byte;
  logic                  w_last_word;
  logic                  w_too_long;
  logic                  w_full;
  logic [BYTE_IDX_W-1:0] w_byte_idx;
  logic [WORD_BITS-1:0]  w_word;

  assign w_start     = start_i && (r_state inside {IDLE, DONE, ERR});
  assign w_fire      = byte_valid_i && byte_ready_o;
  assign w_last_byte = (w_byte_idx == BYTE_IDX_W'(BYTES_PER_WORD - 1));
  assign w_last_word = ((r_word_cnt + 1'b1) == r_len);
  assign w_too_long  = ({1'b0, len_i} > (LEN_WIDTH + 1)'(MAX_WORDS));

  imem_loader_byte_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .i_clear (r_state == WRITE),
    .i_load  (w_fire),
    .i_byte  (byte_i),
    .o_word  (w_word),
    .o_idx   (w_byte_idx),
    .o_full  (w_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, DONE, ERR: begin
        if (start_i) begin
          if (len_i == '0)     w_next = DONE;
          else if (w_too_long) w_next = ERR;
          else                 w_next = RECV;
        end
      end
      RECV:    if (w_fire && w_last_byte) w_next = WRITE;
      WRITE:   w_next = w_last_word ? DONE : RECV;
      default: w_next = IDLE;
    endcase
  end

  // Hold is tracked against the next state so a rejected start leaves it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len       <= '0;
      r_word_cnt  <= '0;
      r_addr      <= BASEADDR;
      r_core_hold <= 1'b1;
    end else begin
      if (w_start) begin
        r_len      <= len_i;
        r_word_cnt <= '0;
        r_addr     <= BASEADDR;
      end else if (r_state == WRITE && !w_last_word) begin
        r_word_cnt <= r_word_cnt + 1'b1;
        r_addr     <= r_addr + AWIDTH'(BYTES_PER_WORD);
      end
      if (w_next == DONE)                          r_core_hold <= 1'b0;
      else if (w_next == RECV || w_next == WRITE)  r_core_hold <= 1'b1;
    end
  end

  assign byte_ready_o   = (r_state == RECV);
  assign mem_write_en_o = (r_state == WRITE) && w_full;
  assign mem_addr_o     = r_addr;
  assign mem_data_o     = DWIDTH'(w_word);
  assign busy_o         = (r_state == RECV) || (r_state == WRITE);
  assign done_o         = (r_state == DONE);
  assign err_o          = (r_state == ERR);
  assign core_hold_o    = r_core_hold;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - directed self-checking bench for the program loader
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_i = 1'b0;
  logic [15:0] len_i = '0;
  logic        byte_valid_i = 1'b0;
  logic [7:0]  byte_i = '0;
  logic        byte_ready_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_data_o;
  logic        mem_write_en_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic        core_hold_o;

  int checks = 0;
  int failures = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];
  int          ready_in_write = 0;

  localparam logic [31:0] BASE = 32'h0100_0000;

  imem_loader dut (
    .clk            (clk),
    .rst            (rst),
    .start_i        (start_i),
    .len_i          (len_i),
    .byte_valid_i   (byte_valid_i),
    .byte_i         (byte_i),
    .byte_ready_o   (byte_ready_o),
    .mem_addr_o     (mem_addr_o),
    .mem_data_o     (mem_data_o),
    .mem_write_en_o (mem_write_en_o),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .err_o          (err_o),
    .core_hold_o    (core_hold_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_write_en_o) begin
      wr_addr.push_back(mem_addr_o);
      wr_data.push_back(mem_data_o);
      if (byte_ready_o) ready_in_write++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    ready_in_write = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic [15:0] len);
    start_i = 1'b1;
    len_i   = len;
    tick();
    start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n = 0;
    byte_valid_i = 1'b1;
    byte_i       = b;
    while (!byte_ready_o && n < 50) begin
      tick();
      n++;
    end
    if (n >= 50) check("ready_timeout", 0, 1);
    tick();
    byte_valid_i = 1'b0;
    if (gap) tick();
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 100) begin
      tick();
      n++;
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_we"},    mem_write_en_o, 0);
    check({tag, "_ready"}, byte_ready_o, 0);
    check({tag, "_busy"},  busy_o, 0);
    check({tag, "_flags"}, {done_o, err_o}, 0);
    check({tag, "_hold"},  core_hold_o, 1);
    check({tag, "_addr"},  mem_addr_o, BASE);
    check({tag, "_data"},  mem_data_o, 0);
  endtask

  task automatic load_image(input bit gap);
    logic [7:0] img[8];
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    clear_log();
    pulse_start(16'd2);
    for (int i = 0; i < 8; i++) begin
      send_byte(img[i], gap);
      if (i == 0) check("hold_during_load", {core_hold_o, busy_o}, 2'b11);
    end
    wait_done();
    check("img_done", done_o, 1);
    check("img_hold_released", core_hold_o, 0);
    check("img_busy", busy_o, 0);
    check("img_nwrites", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("img_w0_addr", wr_addr[0], BASE);
      check("img_w0_data", wr_data[0], 32'h4433_2211);
      check("img_w1_addr", wr_addr[1], BASE + 32'd4);
      check("img_w1_data", wr_data[1], 32'h8877_6655);
    end
    check("img_ready_in_write", ready_in_write, 0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) tick();
    check_reset_outputs("reset");
    rst = 1'b1;
    tick();

    load_image(1'b0);
    load_image(1'b1);

    clear_log();
    pulse_start(16'd0);
    check("len0_done", done_o, 1);
    check("len0_busy", busy_o, 0);
    repeat (3) tick();
    check("len0_nwrites", wr_addr.size(), 0);

    clear_log();
    pulse_start(16'd1025);
    check("toolong_err", {err_o, done_o}, 2'b10);
    check("toolong_busy", busy_o, 0);
    check("toolong_hold_kept", core_hold_o, 0);
    repeat (3) tick();
    check("toolong_nwrites", wr_addr.size(), 0);
    check("toolong_busy_later", busy_o, 0);

    clear_log();
    pulse_start(16'd1);
    check("reload_clears_err", err_o, 0);
    send_byte(8'hA1, 1'b0);
    send_byte(8'hB2, 1'b0);
    pulse_start(16'd3);
    send_byte(8'hC3, 1'b0);
    send_byte(8'hD4, 1'b0);
    wait_done();
    byte_valid_i = 1'b1;
    byte_i       = 8'hEE;
    repeat (3) tick();
    check("idle_ready", byte_ready_o, 0);
    byte_valid_i = 1'b0;
    repeat (5) tick();
    check("midstart_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() == 1) check("midstart_data", wr_data[0], 32'hD4C3_B2A1);

    clear_log();
    pulse_start(16'd2);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    send_byte(8'h55, 1'b0);
    send_byte(8'h66, 1'b0);
    rst = 1'b0;
    #1;
    check_reset_outputs("midrst");
    tick();
    tick();
    check("midrst_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() == 1) check("midrst_w0_data", wr_data[0], 32'h4433_2211);
    rst = 1'b1;
    tick();
    clear_log();
    pulse_start(16'd1);
    send_byte(8'h01, 1'b0);
    send_byte(8'h02, 1'b0);
    send_byte(8'h03, 1'b0);
    send_byte(8'h04, 1'b0);
    wait_done();
    check("fresh_done", done_o, 1);
    check("fresh_nwrites", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      check("fresh_addr", wr_addr[0], BASE);
      check("fresh_data", wr_data[0], 32'h0403_0201);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
